strhw_gn_iter: RTL and testbench

STRHW_GN_ITER -- requirements
Module: strhw_gn_iter

---
 rtl/strhw_gn_iter_if.sv | 43 ++++
 rtl/strhw_gn_iter.sv | 168 ++++++++++++++++
 tb/tb_strhw_gn_iter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/strhw_gn_iter_if.sv
// strhw_gn_iter_if: request/result handshake and external LPS port bundle.
// abort_i exists only when STRHW_GN_ABORT_EN is defined.
interface strhw_gn_iter_if #(
    parameter int TAG_W = 4
);
    logic             in_vld_i;
    logic             in_rdy_o;
    logic [511:0]     h_i;
    logic [511:0]     n_i;
    logic [511:0]     m_i;
    logic             zero_n_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_vld_o;
    logic             out_rdy_i;
    logic [511:0]     result_o;
    logic [TAG_W-1:0] tag_o;
    logic             lps_vld_o;
    logic [511:0]     lps_a_o;
    logic [511:0]     lps_result_i;
`ifdef STRHW_GN_ABORT_EN
    logic             abort_i;
`endif

    modport slave (
`ifdef STRHW_GN_ABORT_EN
        input  abort_i,
`endif
        input  in_vld_i, h_i, n_i, m_i, zero_n_i, tag_i,
        input  out_rdy_i, lps_result_i,
        output in_rdy_o, out_vld_o, result_o, tag_o,
        output lps_vld_o, lps_a_o
    );

    modport master (
`ifdef STRHW_GN_ABORT_EN
        output abort_i,
`endif
        output in_vld_i, h_i, n_i, m_i, zero_n_i, tag_i,
        output out_rdy_i, lps_result_i,
        input  in_rdy_o, out_vld_o, result_o, tag_o,
        input  lps_vld_o, lps_a_o
    );
endinterface

// File: rtl/strhw_gn_iter.sv
// strhw_gn_iter: iterative Streebog g_N(h,m) around an external fixed-latency LPS.
// Define STRHW_GN_ABORT_EN to add the abort_i path.
module strhw_gn_iter #(
    parameter int LPS_LAT   = 1,
    parameter int ROUND_CNT = 12,
    parameter int TAG_W     = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    strhw_gn_iter_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] KEY0  = 3'd1;
    localparam logic [2:0] RND_M = 3'd2;
    localparam logic [2:0] RND_K = 3'd3;
    localparam logic [2:0] FINAL = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [3:0] LAT_C = 4'(LPS_LAT);
    localparam logic [3:0] RND_C = 4'(ROUND_CNT);

    logic [2:0]       r_state;
    logic [3:0]       r_cnt;
    logic [3:0]       r_rnd;
    logic [511:0]     r_h;
    logic [511:0]     r_m;
    logic [511:0]     r_k;
    logic [511:0]     r_s;
    logic [511:0]     r_lps_a;
    logic [511:0]     r_res;
    logic [TAG_W-1:0] r_tag;
    logic [TAG_W-1:0] r_tag_o;
    logic             r_lps_vld;
    logic             r_out_vld;

    logic             w_busy;
    logic             w_smp;
    logic             w_abort;
    logic [511:0]     w_lr;
    logic [511:0]     w_c;

    function automatic logic [511:0] f_c(input logic [3:0] idx);
        logic [511:0] v;
        v = '0;
        case (idx)
            4'd0:  v = 512'hb1085bda1ecadae9ebcb2f81c0657c1f2f6a76432e45d016714eb88d7585c4fc4b7ce09192676901a2422a08a460d31505767436cc744d23dd806559f2a64507;
            4'd1:  v = 512'h6fa3b58aa99d2f1a4fe39d460f70b5d7f3feea720a232b9861d55e0f16b501319ab5176b12d699585cb561c2db0aa7ca55dda21bd7cbcd56e679047021b19bb7;
            4'd2:  v = 512'hf574dcac2bce2fc70a39fc286a3d843506f15e5f529c1f8bf2ea7514b1297b7bd3e20fe490359eb1c1c93a376062db09c2b6f443867adb31991e96f50aba0ab2;
            4'd3:  v = 512'hef1fdfb3e81566d2f948e1a05d71e4dd488e857e335c3c7d9d721cad685e353fa9d72c82ed03d675d8b71333935203be3453eaa193e837f1220cbebc84e3d12e;
            4'd4:  v = 512'h4bea6bacad4747999a3f410c6ca923637f151c1f1686104a359e35d7800fffbdbfcd1747253af5a3dfff00b723271a167a56a27ea9ea63f5601758fd7c6cfe57;
            4'd5:  v = 512'hae4faeae1d3ad3d96fa4c33b7a3039c02d66c4f95142a46c187f9ab49af08ec6cffaa6b71c9ab7b40af21f66c2bec6b6bf71c57236904f35fa68407a46647d6e;
            4'd6:  v = 512'hf4c70e16eeaac5ec51ac86febf240954399ec6c7e6bf87c9d3473e33197a93c90992abc52d822c3706476983284a05043517454ca23c4af38886564d3a14d493;
            4'd7:  v = 512'h9b1f5b424d93c9a703e7aa020c6e41414eb7f8719c36de1e89b4443b4ddbc49af4892bcb929b069069d18d2bd1a5c42f36acc2355951a8d9a47f0dd4bf02e71e;
            4'd8:  v = 512'h378f5a541631229b944c9ad8ec165fde3a7d3a1b258942243cd955b7e00d0984800a440bdbb2ceb17b2b8a9aa6079c540e38dc92cb1f2a607261445183235adb;
            4'd9:  v = 512'habbedea680056f52382ae548b2e4f3f38941e71cff8a78db1fffe18a1b3361039fe76702af69334b7a1e6c303b7652f43698fad1153bb6c374b4c7fb98459ced;
            4'd10: v = 512'h7bcd9ed0efc889fb3002c6cd635afe94d8fa6bbbebab076120018021148466798a1d71efea48b9caefbacd1d7d476e98dea2594ac06fd85d6bcaa4cd81f32d1b;
            4'd11: v = 512'h378ee767f11631bad21380b00449b17acda43c32bcdf1d77f82012d430219f9b5d80ef9d1891cc86e71da4aa88e12852faf417d5d9b21b9948bc924af11bd720;
            default: v = '0;
        endcase
        return v;
    endfunction

    // State names the LPS operation in flight; FINAL carries the last key step.
    assign w_busy = (r_state == KEY0) || (r_state == RND_M) ||
                    (r_state == RND_K) || (r_state == FINAL);
    assign w_smp  = w_busy && (r_cnt == LAT_C);
    assign w_lr   = bus.lps_result_i;
    assign w_c    = f_c(r_rnd - 4'd1);

`ifdef STRHW_GN_ABORT_EN
    assign w_abort = bus.abort_i && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign bus.in_rdy_o  = (r_state == IDLE);
    assign bus.out_vld_o = r_out_vld;
    assign bus.result_o  = r_res;
    assign bus.tag_o     = r_tag_o;
    assign bus.lps_vld_o = r_lps_vld;
    assign bus.lps_a_o   = r_lps_a;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rnd     <= '0;
            r_h       <= '0;
            r_m       <= '0;
            r_k       <= '0;
            r_s       <= '0;
            r_lps_a   <= '0;
            r_res     <= '0;
            r_tag     <= '0;
            r_tag_o   <= '0;
            r_lps_vld <= 1'b0;
            r_out_vld <= 1'b0;
        end else if (w_abort) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_lps_vld <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_lps_vld <= 1'b0;
            if (w_busy) r_cnt <= r_cnt + 4'd1;
            unique case (r_state)
                IDLE: begin
                    if (bus.in_vld_i) begin
                        r_h       <= bus.h_i;
                        r_m       <= bus.m_i;
                        r_tag     <= bus.tag_i;
                        r_lps_a   <= bus.h_i ^ (bus.zero_n_i ? '0 : bus.n_i);
                        r_lps_vld <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= KEY0;
                    end
                end
                KEY0: begin
                    if (w_smp) begin
                        r_k       <= w_lr;
                        r_s       <= r_m;
                        r_rnd     <= 4'd1;
                        r_lps_a   <= w_lr ^ r_m;
                        r_lps_vld <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= RND_M;
                    end
                end
                RND_M: begin
                    if (w_smp) begin
                        r_s       <= w_lr;
                        r_lps_a   <= r_k ^ w_c;
                        r_lps_vld <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= (r_rnd == RND_C) ? FINAL : RND_K;
                    end
                end
                RND_K: begin
                    if (w_smp) begin
                        r_k       <= w_lr;
                        r_rnd     <= r_rnd + 4'd1;
                        r_lps_a   <= w_lr ^ r_s;
                        r_lps_vld <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= RND_M;
                    end
                end
                FINAL: begin
                    if (w_smp) begin
                        r_k       <= w_lr;
                        r_res     <= w_lr ^ r_s ^ r_h ^ r_m;
                        r_tag_o   <= r_tag;
                        r_out_vld <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_rdy_i) begin
                        r_out_vld <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_strhw_gn_iter.sv
// tb_strhw_gn_iter: scoreboard bench for strhw_gn_iter (LPS_LAT 1 and 3).
// The external LPS is emulated by a stand-in permutation with exact latency.
`timescale 1ns/1ps
module tb_strhw_gn_iter;
    localparam int TW = 4;

    localparam logic [511:0] CT [12] = '{
        512'hb1085bda1ecadae9ebcb2f81c0657c1f2f6a76432e45d016714eb88d7585c4fc4b7ce09192676901a2422a08a460d31505767436cc744d23dd806559f2a64507,
        512'h6fa3b58aa99d2f1a4fe39d460f70b5d7f3feea720a232b9861d55e0f16b501319ab5176b12d699585cb561c2db0aa7ca55dda21bd7cbcd56e679047021b19bb7,
        512'hf574dcac2bce2fc70a39fc286a3d843506f15e5f529c1f8bf2ea7514b1297b7bd3e20fe490359eb1c1c93a376062db09c2b6f443867adb31991e96f50aba0ab2,
        512'hef1fdfb3e81566d2f948e1a05d71e4dd488e857e335c3c7d9d721cad685e353fa9d72c82ed03d675d8b71333935203be3453eaa193e837f1220cbebc84e3d12e,
        512'h4bea6bacad4747999a3f410c6ca923637f151c1f1686104a359e35d7800fffbdbfcd1747253af5a3dfff00b723271a167a56a27ea9ea63f5601758fd7c6cfe57,
        512'hae4faeae1d3ad3d96fa4c33b7a3039c02d66c4f95142a46c187f9ab49af08ec6cffaa6b71c9ab7b40af21f66c2bec6b6bf71c57236904f35fa68407a46647d6e,
        512'hf4c70e16eeaac5ec51ac86febf240954399ec6c7e6bf87c9d3473e33197a93c90992abc52d822c3706476983284a05043517454ca23c4af38886564d3a14d493,
        512'h9b1f5b424d93c9a703e7aa020c6e41414eb7f8719c36de1e89b4443b4ddbc49af4892bcb929b069069d18d2bd1a5c42f36acc2355951a8d9a47f0dd4bf02e71e,
        512'h378f5a541631229b944c9ad8ec165fde3a7d3a1b258942243cd955b7e00d0984800a440bdbb2ceb17b2b8a9aa6079c540e38dc92cb1f2a607261445183235adb,
        512'habbedea680056f52382ae548b2e4f3f38941e71cff8a78db1fffe18a1b3361039fe76702af69334b7a1e6c303b7652f43698fad1153bb6c374b4c7fb98459ced,
        512'h7bcd9ed0efc889fb3002c6cd635afe94d8fa6bbbebab076120018021148466798a1d71efea48b9caefbacd1d7d476e98dea2594ac06fd85d6bcaa4cd81f32d1b,
        512'h378ee767f11631bad21380b00449b17acda43c32bcdf1d77f82012d430219f9b5d80ef9d1891cc86e71da4aa88e12852faf417d5d9b21b9948bc924af11bd720
    };

    typedef struct {
        logic [511:0] r;
        logic [3:0]   t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    strhw_gn_iter_if #(.TAG_W(TW)) b0 ();
    strhw_gn_iter_if #(.TAG_W(TW)) b1 ();

    strhw_gn_iter #(.TAG_W(TW)) u0 (
        .clk_i(clk), .rst_i(rst), .bus(b0.slave)
    );
    strhw_gn_iter #(.LPS_LAT(3), .ROUND_CNT(12), .TAG_W(TW)) u1 (
        .clk_i(clk), .rst_i(rst), .bus(b1.slave)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    function automatic logic [511:0] lps_m(input logic [511:0] x);
        logic [511:0] r;
        r = {x[502:0], x[511:503]};
        return r ^ (x >> 13) ^ {8{64'h9E3779B97F4A7C15}};
    endfunction

    function automatic logic [511:0] gn(input logic [511:0] h, n, m,
                                        input logic z);
        logic [511:0] k, s;
        k = lps_m(h ^ (z ? 512'd0 : n));
        s = m;
        for (int i = 0; i < 12; i++) begin
            s = lps_m(k ^ s);
            k = lps_m(k ^ CT[i]);
        end
        return k ^ s ^ h ^ m;
    endfunction

    // LPS emulators: correct result only exactly LAT cycles after issue
    logic         sv0 [0:8];
    logic [511:0] sa0 [0:8];
    logic         sv1 [0:8];
    logic [511:0] sa1 [0:8];
    initial begin
        for (int k = 0; k <= 8; k++) begin
            sv0[k] = 1'b0; sa0[k] = '0; sv1[k] = 1'b0; sa1[k] = '0;
        end
    end
    always @(negedge clk) begin
        for (int k = 8; k > 0; k--) begin
            sv0[k] = sv0[k-1]; sa0[k] = sa0[k-1];
            sv1[k] = sv1[k-1]; sa1[k] = sa1[k-1];
        end
        sv0[0] = b0.lps_vld_o; sa0[0] = b0.lps_a_o;
        sv1[0] = b1.lps_vld_o; sa1[0] = b1.lps_a_o;
        b0.lps_result_i = sv0[1] ? lps_m(sa0[1]) : {16{32'hDEAD0000 ^ $urandom}};
        b1.lps_result_i = sv1[3] ? lps_m(sa1[3]) : {16{32'hBEEF0000 ^ $urandom}};
    end

    // Monitor / scoreboard
    int           acc0, np0, last0 = -100;
    int           acc1, last1 = -100;
    logic         pv0 = 0, pr0 = 0, ph0 = 0, pv1 = 0;
    logic [511:0] hr0;
    logic [3:0]   ht0;
    exp_t         e;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pv0 = 0; pr0 = 0; ph0 = 0; pv1 = 0;
        end else begin
            if (b0.in_vld_i && b0.in_rdy_o) begin acc0 = cyc; np0 = 0; end
            if (b0.lps_vld_o) begin
                np0++;
                n_cmp++;
                if (b0.in_rdy_o || b0.out_vld_o || (cyc - last0) < 2) begin
                    n_bad++;
                    $display("FAIL lps_issue0 cyc=%0d gap=%0d rdy=%0b ovld=%0b required gap>=2 rdy=0 ovld=0",
                             cyc, cyc - last0, b0.in_rdy_o, b0.out_vld_o);
                end
                last0 = cyc;
            end
            if (b0.out_vld_o && !pv0) begin
                n_cmp++;
                if (q0.size() == 0 || cyc - acc0 != 51 || np0 != 25) begin
                    n_bad++;
                    $display("FAIL latency0 lat=%0d pulses=%0d pending=%0d required 51/25/>0",
                             cyc - acc0, np0, q0.size());
                end
            end
            if (b0.out_vld_o && pv0 && !pr0) begin
                n_cmp++;
                if (b0.result_o !== hr0 || b0.tag_o !== ht0 || b0.in_rdy_o) begin
                    n_bad++;
                    $display("FAIL hold0 tag=%h rdy=%0b required tag=%h rdy=0 result stable",
                             b0.tag_o, b0.in_rdy_o, ht0);
                end
            end
            if (ph0) begin
                n_cmp++;
                if (!b0.in_rdy_o) begin
                    n_bad++;
                    $display("FAIL rdy_after_handoff0 in_rdy=%0b required 1", b0.in_rdy_o);
                end
            end
            ph0 = b0.out_vld_o && b0.out_rdy_i;
            if (ph0) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected0 tag=%h required no output", b0.tag_o);
                end else begin
                    e = q0.pop_front();
                    if (b0.result_o !== e.r || b0.tag_o !== e.t) begin
                        n_bad++;
                        $display("FAIL result0 tag=%h res=%h required tag=%h res=%h",
                                 b0.tag_o, b0.result_o[63:0], e.t, e.r[63:0]);
                    end
                end
            end
            pv0 = b0.out_vld_o; pr0 = b0.out_rdy_i;
            hr0 = b0.result_o;  ht0 = b0.tag_o;

            if (b1.in_vld_i && b1.in_rdy_o) acc1 = cyc;
            if (b1.lps_vld_o) begin
                n_cmp++;
                if (b1.in_rdy_o || b1.out_vld_o || (cyc - last1) < 4) begin
                    n_bad++;
                    $display("FAIL lps_issue1 cyc=%0d gap=%0d required gap>=4 busy", cyc, cyc - last1);
                end
                last1 = cyc;
            end
            if (b1.out_vld_o && !pv1) begin
                n_cmp++;
                if (cyc - acc1 != 101) begin
                    n_bad++;
                    $display("FAIL latency1 lat=%0d required 101", cyc - acc1);
                end
            end
            if (b1.out_vld_o && b1.out_rdy_i) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected1 tag=%h required no output", b1.tag_o);
                end else begin
                    e = q1.pop_front();
                    if (b1.result_o !== e.r || b1.tag_o !== e.t) begin
                        n_bad++;
                        $display("FAIL result1 tag=%h res=%h required tag=%h res=%h",
                                 b1.tag_o, b1.result_o[63:0], e.t, e.r[63:0]);
                    end
                end
            end
            pv1 = b1.out_vld_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got=%h required=%h", nm, act[63:0], req[63:0]);
        end
    endtask

    task automatic issue0(input logic [511:0] h, n, m, input logic z,
                          input logic [3:0] t, input bit push);
        int w;
        w = 0;
        while (!b0.in_rdy_o && w < 300) begin step(); w++; end
        chk("issue0_rdy", 512'(b0.in_rdy_o), 512'd1);
        b0.h_i = h; b0.n_i = n; b0.m_i = m; b0.zero_n_i = z; b0.tag_i = t;
        b0.in_vld_i = 1'b1;
        if (push) q0.push_back(exp_t'{gn(h, n, m, z), t});
        step();
        b0.in_vld_i = 1'b0;
    endtask

    task automatic drain0();
        int w;
        w = 0;
        while ((q0.size() != 0 || !b0.in_rdy_o) && w < 400) begin step(); w++; end
        n_cmp++;
        if (w >= 400) begin
            n_bad++;
            $display("FAIL drain0_timeout pending=%0d required 0", q0.size());
        end
    endtask

    logic [511:0] HA, MA, HC, NC, MC, rh, rn, rm, pres;
    logic [3:0]   ptag;
    initial begin
        HA = {8{64'h0123456789ABCDEF}};
        MA = {8{64'hFEDCBA9876543210}};
        HC = {16{32'hA5A53C3C}};
        NC = {16{32'h13579BDF}};
        MC = {4{128'h00112233445566778899AABBCCDDEEFF}};
        rst = 1'b1;
        b0.in_vld_i = 0; b0.h_i = '0; b0.n_i = '0; b0.m_i = '0;
        b0.zero_n_i = 0; b0.tag_i = '0; b0.out_rdy_i = 1'b1;
        b1.in_vld_i = 0; b1.h_i = '0; b1.n_i = '0; b1.m_i = '0;
        b1.zero_n_i = 0; b1.tag_i = '0; b1.out_rdy_i = 1'b1;
`ifdef STRHW_GN_ABORT_EN
        b0.abort_i = 1'b0; b1.abort_i = 1'b0;
`endif
        repeat (3) step();
        rst = 1'b0;
        chk("rst_in_rdy", 512'(b0.in_rdy_o), 512'd1);
        chk("rst_out_vld", 512'(b0.out_vld_o), 512'd0);
        chk("rst_lps_vld", 512'(b0.lps_vld_o), 512'd0);
        chk("rst_result", b0.result_o, 512'd0);
        chk("rst_tag", 512'(b0.tag_o), 512'd0);
        chk("rst_lps_a", b0.lps_a_o, 512'd0);

        issue0('0, '0, '0, 1'b0, 4'h1, 1);
        drain0();
        issue0(HA, 512'h200, MA, 1'b1, 4'h2, 1);
        drain0();
        issue0(HA, 512'd0, MA, 1'b0, 4'h3, 1);
        drain0();

        // result held under back-pressure while stray requests arrive
        b0.out_rdy_i = 1'b0;
        issue0(HC, NC, MC, 1'b0, 4'h4, 1);
        for (int w = 0; w < 200 && !b0.out_vld_o; w++) step();
        for (int i = 0; i < 20; i++) begin
            b0.in_vld_i = i[0];
            b0.tag_i = 4'hF;
            b0.h_i = MC;
            step();
        end
        b0.in_vld_i = 1'b0;
        b0.out_rdy_i = 1'b1;
        drain0();

        issue0(MC, HA, HC, 1'b0, 4'h6, 0);
        repeat (29) step();
        rst = 1'b1;
        step();
        chk("midrst_out_vld", 512'(b0.out_vld_o), 512'd0);
        chk("midrst_lps_vld", 512'(b0.lps_vld_o), 512'd0);
        chk("midrst_in_rdy", 512'(b0.in_rdy_o), 512'd1);
        chk("midrst_result", b0.result_o, 512'd0);
        rst = 1'b0;
        repeat (6) step();
        issue0(NC, MC, HA, 1'b0, 4'h7, 1);
        drain0();

`ifdef STRHW_GN_ABORT_EN
        pres = b0.result_o;
        ptag = b0.tag_o;
        issue0(HA, HC, NC, 1'b0, 4'h8, 0);
        repeat (9) step();
        b0.abort_i = 1'b1;
        step();
        b0.abort_i = 1'b0;
        chk("abort_in_rdy", 512'(b0.in_rdy_o), 512'd1);
        chk("abort_out_vld", 512'(b0.out_vld_o), 512'd0);
        chk("abort_result", b0.result_o, pres);
        chk("abort_tag", 512'(b0.tag_o), 512'(ptag));
        repeat (6) step();
        issue0(HC, HA, MA, 1'b0, 4'h9, 1);
        drain0();
`else
        pres = '0;
        ptag = '0;
`endif

        for (int i = 0; i < 16; i++) begin
            rh[i*32 +: 32] = $urandom;
            rn[i*32 +: 32] = $urandom;
            rm[i*32 +: 32] = $urandom;
        end
        b1.h_i = rh; b1.n_i = rn; b1.m_i = rm; b1.zero_n_i = 1'b0;
        b1.tag_i = 4'hA; b1.in_vld_i = 1'b1;
        q1.push_back(exp_t'{gn(rh, rn, rm, 1'b0), 4'hA});
        step();
        b1.in_vld_i = 1'b0;
        for (int w = 0; w < 300 && q1.size() != 0; w++) step();
        repeat (3) step();

        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL pending q0=%0d q1=%0d required 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d required completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
